// File: rtl/intr_receiver.sv
// Interrupt receiver: synchronises request lines, latches edge/level pending
// state, and runs a fixed-priority IDLE/REQ/SERVICE handshake with the CPU.
module intr_receiver #(
  parameter int NSRC  = 8,
  parameter int VEC_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NSRC-1:0]  INTR_IN,
  input  logic [NSRC-1:0]  MASK,
  input  logic [NSRC-1:0]  EDGE,
  output logic             IRQ,
  input  logic             ACK,
  output logic [VEC_W-1:0] VECTOR,
  output logic             VECTOR_VALID,
  input  logic             EOI,
  output logic [NSRC-1:0]  PENDING,
  output logic [1:0]       fsm_state
);

  // Handshake: IRQ is high only in REQ. An ACK pulse while IRQ is high
  // claims the lowest eligible source; VECTOR_VALID strobes one cycle with
  // the new VECTOR. EOI in SERVICE returns to IDLE. ACK/EOI elsewhere are ignored.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [NSRC-1:0]  s1, s2, s3;
  logic [NSRC-1:0]  pend, pend_next;
  logic [NSRC-1:0]  eligible, win_onehot, clr, rise;
  logic [VEC_W-1:0] win_idx;
  logic             any_elig, ack_take;

  assign eligible   = pend & ~MASK;
  assign any_elig   = |eligible;
  assign win_onehot = eligible & (~eligible + NSRC'(1));

  always_comb begin
    win_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_idx = VEC_W'(i);
    end
  end

  always_comb begin
    state_next = state;
    ack_take   = 1'b0;
    case (state)
      IDLE: begin
        if (any_elig) state_next = REQ;
      end
      REQ: begin
        // A request whose source vanished is withdrawn even if ACK arrives.
        if (!any_elig) begin
          state_next = IDLE;
        end else if (ACK) begin
          ack_take   = 1'b1;
          state_next = SERVICE;
        end
      end
      SERVICE: begin
        if (EOI) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Edge lines: a new edge in the same cycle as the ACK clear keeps the bit set.
  assign rise      = s2 & ~s3;
  assign clr       = ack_take ? win_onehot : '0;
  assign pend_next = (EDGE & (rise | (pend & ~clr))) | (~EDGE & s2);

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1           <= '0;
      s2           <= '0;
      s3           <= '0;
      pend         <= '0;
      state        <= IDLE;
      VECTOR       <= '0;
      VECTOR_VALID <= 1'b0;
    end else begin
      s1           <= INTR_IN;
      s2           <= s1;
      s3           <= s2;
      pend         <= pend_next;
      state        <= state_next;
      VECTOR_VALID <= ack_take;
      if (ack_take) VECTOR <= win_idx;
    end
  end

  assign IRQ       = (state == REQ);
  assign PENDING   = pend;
  assign fsm_state = state;

endmodule

// File: tb/tb_intr_receiver.sv
// Directed bench for intr_receiver: latency, priority, masking, withdrawal,
// SERVICE behaviour, back-to-back servicing and reset.
module tb_intr_receiver;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  logic       clk;
  logic       rst;
  logic [7:0] intr_in;
  logic [7:0] mask;
  logic [7:0] edge_mode;
  logic       irq;
  logic       ack;
  logic [2:0] vector;
  logic       vector_valid;
  logic       eoi;
  logic [7:0] pending;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;

  intr_receiver #(.NSRC(8), .VEC_W(3)) dut (
    .CLK          (clk),
    .RST          (rst),
    .INTR_IN      (intr_in),
    .MASK         (mask),
    .EDGE         (edge_mode),
    .IRQ          (irq),
    .ACK          (ack),
    .VECTOR       (vector),
    .VECTOR_VALID (vector_valid),
    .EOI          (eoi),
    .PENDING      (pending),
    .fsm_state    (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; inputs change and outputs are sampled 1ns later.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [7:0] bits);
    intr_in = intr_in | bits;
    tick(2);
    intr_in = intr_in & ~bits;
  endtask

  task automatic test_reset();
    rst = 1'b1; intr_in = '0; mask = '0; edge_mode = 8'hFF; ack = 0; eoi = 0;
    tick(2);
    rst = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %0b want 0", irq); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending: got %02h want 00", pending); end
    checks++; if (vector !== 3'd0 || vector_valid !== 1'b0) begin errors++; $display("FAIL reset_vector: got %0d/%0b want 0/0", vector, vector_valid); end
    checks++; if (fsm_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", fsm_state, S_IDLE); end
  endtask

  task automatic test_latency_ack();
    intr_in = 8'h20;
    tick(2);
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL lat_pend_e2: got %02h want 00", pending); end
    tick(1);
    checks++; if (pending !== 8'h20 || irq !== 1'b0) begin errors++; $display("FAIL lat_pend_e3: got %02h/%0b want 20/0", pending, irq); end
    tick(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL lat_irq_e4: got %0b want 1", irq); end
    ack = 1; tick(1); ack = 0;
    checks++; if (vector !== 3'd5 || vector_valid !== 1'b1) begin errors++; $display("FAIL ack5_vec: got %0d/%0b want 5/1", vector, vector_valid); end
    checks++; if (pending !== 8'h00 || irq !== 1'b0 || fsm_state !== S_SERVICE) begin errors++; $display("FAIL ack5_state: got %02h/%0b/%0d want 00/0/2", pending, irq, fsm_state); end
    tick(1);
    checks++; if (vector_valid !== 1'b0 || vector !== 3'd5) begin errors++; $display("FAIL ack5_strobe: got %0b/%0d want 0/5", vector_valid, vector); end
    eoi = 1; tick(1); eoi = 0;
    checks++; if (fsm_state !== S_IDLE || irq !== 1'b0) begin errors++; $display("FAIL eoi5: got %0d/%0b want 0/0", fsm_state, irq); end
    intr_in = '0;
    tick(4);
  endtask

  task automatic test_back_to_back();
    pulse(8'h44);
    tick(2);
    checks++; if (irq !== 1'b1 || pending !== 8'h44) begin errors++; $display("FAIL b2b_irq: got %0b/%02h want 1/44", irq, pending); end
    ack = 1; tick(1); ack = 0;
    checks++; if (vector !== 3'd2 || pending !== 8'h40) begin errors++; $display("FAIL b2b_first: got %0d/%02h want 2/40", vector, pending); end
    eoi = 1; tick(1); eoi = 0;
    checks++; if (fsm_state !== S_IDLE || irq !== 1'b0) begin errors++; $display("FAIL b2b_eoi: got %0d/%0b want 0/0", fsm_state, irq); end
    tick(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL b2b_reraise: got %0b want 1", irq); end
    ack = 1; eoi = 1; tick(1); ack = 0; eoi = 0;
    checks++; if (vector !== 3'd6 || vector_valid !== 1'b1 || fsm_state !== S_SERVICE) begin errors++; $display("FAIL b2b_second: got %0d/%0b/%0d want 6/1/2", vector, vector_valid, fsm_state); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL b2b_pend: got %02h want 00", pending); end
    eoi = 1; tick(1); eoi = 0;
  endtask

  task automatic test_level_withdraw();
    int valid_seen;
    valid_seen = 0;
    edge_mode = 8'hF7;
    intr_in = 8'h08;
    tick(4);
    checks++; if (irq !== 1'b1 || pending !== 8'h08) begin errors++; $display("FAIL lvl_irq: got %0b/%02h want 1/08", irq, pending); end
    intr_in = '0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (vector_valid) valid_seen++;
    end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL lvl_hold: got %0b want 1", irq); end
    tick(1);
    if (vector_valid) valid_seen++;
    checks++; if (irq !== 1'b0 || fsm_state !== S_IDLE) begin errors++; $display("FAIL lvl_withdraw: got %0b/%0d want 0/0", irq, fsm_state); end
    checks++; if (vector !== 3'd6 || valid_seen !== 0) begin errors++; $display("FAIL lvl_vector: got %0d/%0d want 6/0", vector, valid_seen); end
    edge_mode = 8'hFF;
    tick(2);
  endtask

  task automatic test_mask();
    mask = 8'h10;
    pulse(8'h10);
    tick(3);
    checks++; if (pending !== 8'h10 || irq !== 1'b0) begin errors++; $display("FAIL mask_block: got %02h/%0b want 10/0", pending, irq); end
    mask = 8'h00;
    tick(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mask_release: got %0b want 1", irq); end
    ack = 1; tick(1); ack = 0;
    checks++; if (vector !== 3'd4 || vector_valid !== 1'b1 || pending !== 8'h00) begin errors++; $display("FAIL mask_ack: got %0d/%0b/%02h want 4/1/00", vector, vector_valid, pending); end
    eoi = 1; tick(1); eoi = 0;
  endtask

  task automatic test_service();
    pulse(8'h80);
    tick(2);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL svc_irq7: got %0b want 1", irq); end
    ack = 1; tick(1); ack = 0;
    checks++; if (vector !== 3'd7) begin errors++; $display("FAIL svc_vec7: got %0d want 7", vector); end
    pulse(8'h02);
    tick(3);
    checks++; if (irq !== 1'b0 || pending !== 8'h02 || fsm_state !== S_SERVICE) begin errors++; $display("FAIL svc_latch: got %0b/%02h/%0d want 0/02/2", irq, pending, fsm_state); end
    ack = 1; tick(1); ack = 0;
    checks++; if (vector !== 3'd7 || vector_valid !== 1'b0 || fsm_state !== S_SERVICE || pending !== 8'h02) begin errors++; $display("FAIL svc_ack_ignored: got %0d/%0b/%0d/%02h want 7/0/2/02", vector, vector_valid, fsm_state, pending); end
    eoi = 1; tick(1); eoi = 0;
    checks++; if (fsm_state !== S_IDLE || irq !== 1'b0) begin errors++; $display("FAIL svc_eoi: got %0d/%0b want 0/0", fsm_state, irq); end
    tick(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL svc_reraise: got %0b want 1", irq); end
    ack = 1; tick(1); ack = 0;
    checks++; if (vector !== 3'd1 || vector_valid !== 1'b1) begin errors++; $display("FAIL svc_vec1: got %0d/%0b want 1/1", vector, vector_valid); end
    eoi = 1; tick(1); eoi = 0;
    eoi = 1; tick(1); eoi = 0;
    checks++; if (fsm_state !== S_IDLE || irq !== 1'b0) begin errors++; $display("FAIL idle_eoi_ignored: got %0d/%0b want 0/0", fsm_state, irq); end
  endtask

  task automatic test_reset_mid();
    pulse(8'h04);
    tick(2);
    ack = 1; tick(1); ack = 0;
    pulse(8'h81);
    tick(2);
    checks++; if (pending !== 8'h81 || fsm_state !== S_SERVICE || vector !== 3'd2) begin errors++; $display("FAIL rstmid_pre: got %02h/%0d/%0d want 81/2/2", pending, fsm_state, vector); end
    rst = 1; tick(1); rst = 0;
    checks++; if (pending !== 8'h00 || irq !== 1'b0 || vector !== 3'd0 || fsm_state !== S_IDLE) begin errors++; $display("FAIL rstmid_post: got %02h/%0b/%0d/%0d want 00/0/0/0", pending, irq, vector, fsm_state); end
    ack = 1; tick(1); ack = 0;
    checks++; if (vector_valid !== 1'b0 || vector !== 3'd0 || fsm_state !== S_IDLE) begin errors++; $display("FAIL rstmid_ack: got %0b/%0d/%0d want 0/0/0", vector_valid, vector, fsm_state); end
  endtask

  task automatic test_high_at_reset();
    intr_in = 8'h08;
    rst = 1; tick(3); rst = 0;
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL hiwr_during: got %02h want 00", pending); end
    tick(3);
    checks++; if (pending !== 8'h08) begin errors++; $display("FAIL hiwr_pend: got %02h want 08", pending); end
    tick(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL hiwr_irq: got %0b want 1", irq); end
    ack = 1; tick(1); ack = 0;
    checks++; if (vector !== 3'd3 || pending !== 8'h00) begin errors++; $display("FAIL hiwr_ack: got %0d/%02h want 3/00", vector, pending); end
  endtask

  initial begin
    test_reset();
    test_latency_ack();
    test_back_to_back();
    test_level_withdraw();
    test_mask();
    test_service();
    test_reset_mid();
    test_high_at_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
